// File: rtl/mips_cpu_if.sv
// Instruction/retire bus for mips_cpu.
// The bench (master) drives the execute enable and the instruction word.
// The CPU (slave) returns the fetch address, the write-back report and the
// halt flag.
interface mips_cpu_if;
  logic        pcEn;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        op_done;

  modport master (
    output pcEn, inst,
    input  pc, wb_en, wb_addr, wb_data, op_done
  );

  modport slave (
    input  pcEn, inst,
    output pc, wb_en, wb_addr, wb_data, op_done
  );
endinterface

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS subset core.
// Supported: ADD/SUB/AND/OR (+SLT), ADDI, LW, SW, BEQ, J and HALT (0xFFFFFFFF).
// Every other encoding retires as a NOP.
// Optional feature macro: MIPS_SLT_EN.
//   defined   -> SLT (funct 0x2A) is implemented as a signed compare.
//   undefined -> funct 0x2A retires as a NOP.
// Reset is synchronous and active-low. It clears the pc, the write-back
// report, the halt flag and the register file. Data memory keeps its
// contents across reset.
module mips_cpu (
  input  logic clk,
  input  logic reset,
  mips_cpu_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Architectural state
  logic [31:0] r_pc;
  logic [31:0] r_regs [32];
  logic [31:0] r_dmem [64];
  logic        r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        r_op_done;

  // Instruction fields
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic [31:0] w_pc4;

  // Operands and decode results
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [5:0]  w_midx;
  logic [31:0] w_mem_rdata;
  logic        w_halt;
  logic        w_retire;
  logic        w_rf_we;
  logic [4:0]  w_rf_wa;
  logic [31:0] w_rf_wd;
  logic        w_mem_we;
  logic [31:0] w_pc_next;

  assign w_opcode = bus.inst[31:26];
  assign w_rs     = bus.inst[25:21];
  assign w_rt     = bus.inst[20:16];
  assign w_rd     = bus.inst[15:11];
  assign w_funct  = bus.inst[5:0];
  assign w_imm    = bus.inst[15:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_pc4    = r_pc + 32'd4;

  // $0 is hard-wired to zero on the read side, so its storage never matters.
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  // Only address bits [7:2] select a word. The low byte of rs + sext(imm)
  // depends only on the low bytes of the operands, so the full 32-bit sum
  // is never needed here.
  assign w_midx      = 6'((w_rs_val[7:0] + w_imm[7:0]) >> 2);
  assign w_mem_rdata = r_dmem[w_midx];

  assign w_halt   = (bus.inst == 32'hFFFF_FFFF);
  assign w_retire = bus.pcEn && !r_op_done;

  // Signed less-than, used by SLT
  function automatic logic [31:0] slt_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    return (a < b) ? 32'd1 : 32'd0;
  endfunction

  // Decode: pick register/memory writes and the next pc for the current instruction
  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_wa   = 5'd0;
    w_rf_wd   = 32'd0;
    w_mem_we  = 1'b0;
    w_pc_next = w_pc4;
    if (w_halt) begin
      w_pc_next = r_pc;
    end else begin
      case (w_opcode)
        OP_RTYPE: begin
          w_rf_wa = w_rd;
          case (w_funct)
            FN_ADD: begin w_rf_we = 1'b1; w_rf_wd = w_rs_val + w_rt_val; end
            FN_SUB: begin w_rf_we = 1'b1; w_rf_wd = w_rs_val - w_rt_val; end
            FN_AND: begin w_rf_we = 1'b1; w_rf_wd = w_rs_val & w_rt_val; end
            FN_OR:  begin w_rf_we = 1'b1; w_rf_wd = w_rs_val | w_rt_val; end
`ifdef MIPS_SLT_EN
            FN_SLT: begin w_rf_we = 1'b1; w_rf_wd = slt_signed(w_rs_val, w_rt_val); end
`else
            FN_SLT: begin w_rf_we = 1'b0; w_rf_wd = slt_signed(w_rs_val, w_rt_val); end
`endif
            default: w_rf_we = 1'b0;
          endcase
        end
        OP_ADDI: begin
          w_rf_we = 1'b1;
          w_rf_wa = w_rt;
          w_rf_wd = w_rs_val + w_sext;
        end
        OP_LW: begin
          w_rf_we = 1'b1;
          w_rf_wa = w_rt;
          w_rf_wd = w_mem_rdata;
        end
        OP_SW: begin
          w_mem_we = 1'b1;
        end
        OP_BEQ: begin
          if (w_rs_val == w_rt_val)
            w_pc_next = w_pc4 + {w_sext[29:0], 2'b00};
        end
        OP_J: begin
          w_pc_next = {w_pc4[31:28], bus.inst[25:0], 2'b00};
        end
        default: w_pc_next = w_pc4;
      endcase
    end
  end

  // pc, write-back report and halt flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= 32'd0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= 5'd0;
      r_wb_data <= 32'd0;
      r_op_done <= 1'b0;
    end else if (w_retire) begin
      r_pc    <= w_pc_next;
      r_wb_en <= w_rf_we && (w_rf_wa != 5'd0);
      if (w_rf_we && (w_rf_wa != 5'd0)) begin
        r_wb_addr <= w_rf_wa;
        r_wb_data <= w_rf_wd;
      end
      if (w_halt)
        r_op_done <= 1'b1;
    end else begin
      r_wb_en <= 1'b0;
    end
  end

  // Register file: cleared by reset, written on retire, $0 never written
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= 32'd0;
    end else if (w_retire && w_rf_we && (w_rf_wa != 5'd0)) begin
      r_regs[w_rf_wa] <= w_rf_wd;
    end
  end

  // Data memory: no reset; a store is dropped when reset is asserted on the same edge
  always_ff @(posedge clk) begin
    if (reset && w_retire && w_mem_we)
      r_dmem[w_midx] <= w_rt_val;
  end

  assign bus.pc      = r_pc;
  assign bus.wb_en   = r_wb_en;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;
  assign bus.op_done = r_op_done;

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu.
// Each step drives one edge's inputs, pushes the expected post-edge state
// onto a scoreboard, then pops it and compares it with the DUT outputs.
module tb_mips_cpu;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mips_cpu_if u_if ();

  mips_cpu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        done;
  } exp_t;

  exp_t sb[$];

  // Count one comparison and report it if it does not match
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one edge, then compare the outputs against the scoreboard entry
  task automatic step(input string tag, input logic rst_n, input logic en,
                      input logic [31:0] ins, input logic e_en, input logic [4:0] e_addr,
                      input logic [31:0] e_data, input logic [31:0] e_pc, input logic e_done);
    exp_t e;
    exp_t got;
    e.en = e_en; e.addr = e_addr; e.data = e_data; e.pc = e_pc; e.done = e_done;
    reset       = rst_n;
    u_if.pcEn   = en;
    u_if.inst   = ins;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, ".wb_en"},   {31'd0, u_if.wb_en},   {31'd0, got.en});
      chk({tag, ".wb_addr"}, {27'd0, u_if.wb_addr}, {27'd0, got.addr});
      chk({tag, ".wb_data"}, u_if.wb_data,          got.data);
      chk({tag, ".pc"},      u_if.pc,               got.pc);
      chk({tag, ".op_done"}, {31'd0, u_if.op_done}, {31'd0, got.done});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    u_if.pcEn = 1'b0;
    u_if.inst = 32'd0;
    @(posedge clk);
    // Reset state, with an instruction in flight and pcEn high
    step("rst",    1'b0, 1'b1, 32'h2001_0005, 1'b0, 5'd0,  32'd0,          32'h00, 1'b0);

    step("addi1",  1'b1, 1'b1, 32'h2001_0005, 1'b1, 5'd1,  32'd5,          32'h04, 1'b0);
    step("addi2",  1'b1, 1'b1, 32'h2002_0003, 1'b1, 5'd2,  32'd3,          32'h08, 1'b0);
    step("add",    1'b1, 1'b1, 32'h0022_1820, 1'b1, 5'd3,  32'd8,          32'h0C, 1'b0);
    step("sub",    1'b1, 1'b1, 32'h0022_2022, 1'b1, 5'd4,  32'd2,          32'h10, 1'b0);
    step("sw",     1'b1, 1'b1, 32'hAC03_0000, 1'b0, 5'd4,  32'd2,          32'h14, 1'b0);
    step("lw",     1'b1, 1'b1, 32'h8C05_0000, 1'b1, 5'd5,  32'd8,          32'h18, 1'b0);
    step("beq_t",  1'b1, 1'b1, 32'h1021_0002, 1'b0, 5'd5,  32'd8,          32'h24, 1'b0);
    step("j",      1'b1, 1'b1, 32'h0800_0010, 1'b0, 5'd5,  32'd8,          32'h40, 1'b0);
`ifdef MIPS_SLT_EN
    step("slt",    1'b1, 1'b1, 32'h0041_302A, 1'b1, 5'd6,  32'd1,          32'h44, 1'b0);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b1, 1'b0, 32'h2007_0009, 1'b0, 5'd6, 32'd1,          32'h44, 1'b0);
    step("r0_wr",  1'b1, 1'b1, 32'h2000_0007, 1'b0, 5'd6,  32'd1,          32'h48, 1'b0);
`else
    step("slt",    1'b1, 1'b1, 32'h0041_302A, 1'b0, 5'd5,  32'd8,          32'h44, 1'b0);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b1, 1'b0, 32'h2007_0009, 1'b0, 5'd5, 32'd8,          32'h44, 1'b0);
    step("r0_wr",  1'b1, 1'b1, 32'h2000_0007, 1'b0, 5'd5,  32'd8,          32'h48, 1'b0);
`endif
    step("r0_rd",  1'b1, 1'b1, 32'h0000_4020, 1'b1, 5'd8,  32'd0,          32'h4C, 1'b0);
    step("subwr",  1'b1, 1'b1, 32'h0041_4822, 1'b1, 5'd9,  32'hFFFF_FFFE,  32'h50, 1'b0);
    step("and",    1'b1, 1'b1, 32'h0022_5024, 1'b1, 5'd10, 32'd1,          32'h54, 1'b0);
    step("or",     1'b1, 1'b1, 32'h0022_5825, 1'b1, 5'd11, 32'd7,          32'h58, 1'b0);
    step("nop_op", 1'b1, 1'b1, 32'h3C01_FFFF, 1'b0, 5'd11, 32'd7,          32'h5C, 1'b0);
    step("beq_nt", 1'b1, 1'b1, 32'h1022_0004, 1'b0, 5'd11, 32'd7,          32'h60, 1'b0);
    step("addineg",1'b1, 1'b1, 32'h200C_FFFF, 1'b1, 5'd12, 32'hFFFF_FFFF,  32'h64, 1'b0);
`ifdef MIPS_SLT_EN
    step("slt_sg", 1'b1, 1'b1, 32'h0181_682A, 1'b1, 5'd13, 32'd1,          32'h68, 1'b0);
`else
    step("slt_sg", 1'b1, 1'b1, 32'h0181_682A, 1'b0, 5'd12, 32'hFFFF_FFFF,  32'h68, 1'b0);
`endif
    // Store to 0x101: bits [31:8] and [1:0] ignored, so word 0 gets $1 = 5
    step("sw_alias",1'b1,1'b1, 32'hAC01_0101, 1'b0, 5'd12, 32'hFFFF_FFFF,  32'h6C, 1'b0);
    step("lw_alias",1'b1,1'b1, 32'h8C0E_0000, 1'b1, 5'd14, 32'd5,          32'h70, 1'b0);
    step("halt",   1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd14, 32'd5,          32'h70, 1'b1);
    step("halted", 1'b1, 1'b1, 32'h2001_0009, 1'b0, 5'd14, 32'd5,          32'h70, 1'b1);
    // Reset wins over HALT and pcEn on the same edge
    step("rst2",   1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'd0,          32'h00, 1'b0);
    // Data memory survives reset; registers do not
    step("lw_keep",1'b1, 1'b1, 32'h8C0F_0000, 1'b1, 5'd15, 32'd5,          32'h04, 1'b0);
    step("reg_clr",1'b1, 1'b1, 32'h0020_8020, 1'b1, 5'd16, 32'd0,          32'h08, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu.md
MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-003 pcEn  input  1  execute enable; 1 = retire inst this edge, 0 = stall (no state change).
REQ-004 inst  input  32  instruction word for the address on pc, valid before the next rising edge.
REQ-005 pc  output  32  byte address of the current instruction, registered.
REQ-006 wb_en  output  1  registered; 1 for one cycle after an edge that wrote a nonzero register.
REQ-007 wb_addr  output  5  registered destination register of the last write.
REQ-008 wb_data  output  32  registered value of the last write.
REQ-009 op_done  output  1  sticky; set when HALT retires.

Function
REQ-010 The design SHALL be single-cycle: on each rising edge with reset=1, pcEn=1 and op_done=0, inst SHALL be fully retired (register, memory and pc updates).
REQ-011 With pcEn=0 or op_done=1, pc, register file and data memory SHALL hold; wb_en SHALL be 0.
REQ-012 Register file: 32x32; reads combinational; $0 reads 0 and ignores writes.
REQ-013 Data memory: 64x32 words, word index = address[7:2], address bits [31:8] and [1:0] ignored; read combinational, write on edge.
REQ-014 R-type (opcode 0x00), funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A; rd <= result; arithmetic wraps modulo 2^32, no overflow trap.
REQ-015 ADDI 0x08: rt <= rs + sext(imm16).
REQ-016 LW 0x23: rt <= mem[rs + sext(imm16)]; SW 0x2B: mem[rs + sext(imm16)] <= rt.
REQ-017 BEQ 0x04: if rs==rt, pc <= pc+4 + (sext(imm16)<<2), else pc+4.
REQ-018 J 0x02: pc <= {pc+4 [31:28], target26, 2'b00}.
REQ-019 HALT = inst 0xFFFF_FFFF: op_done <= 1, pc holds; op_done stays 1 until reset.
REQ-020 Any other opcode/funct SHALL retire as a NOP (pc+4, no writes).
REQ-021 Otherwise pc <= pc+4, wrapping from 0xFFFF_FFFC to 0.
REQ-022 SLT SHALL compare signed: rd <= 1 if rs < rt, else 0.
REQ-023 Write to $0 SHALL leave wb_en=0.

Reset
REQ-024 reset=0 at a rising edge SHALL set pc=0, wb_en=0, wb_addr=0, wb_data=0, op_done=0 and clear all registers, overriding pcEn and any instruction in flight.
REQ-025 Data memory SHALL NOT be cleared by reset.
REQ-026 Reset SHALL take precedence over HALT and pcEn in the same cycle.

Configuration
REQ-027 Macro MIPS_SLT_EN: defined -> SLT (REQ-014, REQ-022) is implemented; undefined -> funct 0x2A SHALL decode as NOP per REQ-020.

Verification
REQ-028 Reset, then pcEn=1, inst 0x20010005 (ADDI $1,$0,5) -> next cycle wb_en=1, wb_addr=1, wb_data=5, pc=0x4.
REQ-029 ADDI $2,$0,3 (0x20020003), ADD $3,$1,$2 (0x00221820), SUB $4,$1,$2 (0x00222022) -> wb_data 3, 8, 2; pc=0x10.
REQ-030 SW $3,0($0) (0xAC030000), then LW $5,0($0) (0x8C050000) -> wb_en=0 after SW; after LW wb_addr=5, wb_data=8.
REQ-031 BEQ $1,$1,+2 (0x10210002) at pc=0x18 -> pc=0x24; J 0x10 (0x08000010) -> pc=0x40.
REQ-032 SLT $6,$2,$1 (0x0041302A) -> wb_data=1 with MIPS_SLT_EN, wb_en=0 without; pcEn=0 for 3 cycles -> pc unchanged.
REQ-033 inst 0xFFFFFFFF -> op_done=1, pc frozen; then reset=0 for one edge -> op_done=0, pc=0.
